// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the fetch front end.
// The optional FETCH_STATS_EN counters use sat_add.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INST_W  = 32;
  localparam int ENTRY_W = XLEN + INST_W;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Saturating 32-bit add for event counters.
  function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [31:0] inc);
    logic [32:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {pc, inst} FIFO with flush.
// The head entry is read straight from registered storage.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [CW-1:0]      count,
  output logic [ENTRY_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE_C = CW'(1);
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO_C = AW'(0);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic               do_push_s;
  logic               do_pop_s;

  // Qualify push/pop; a push into a full FIFO is only taken alongside a pop.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (flush) begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
    end else begin
      do_pop_s  = pop && (count_r != ZERO_C);
      do_push_s = push && ((count_r != FULL_C) || do_pop_s);
    end
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO_C;
      rd_ptr_r <= PTR_ZERO_C;
      count_r  <= ZERO_C;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO_C;
      rd_ptr_r <= PTR_ZERO_C;
      count_r  <= ZERO_C;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE_C;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_queue_chk.sv
// Simulation checks for the fetch queue: memory protocol and occupancy bound.
module fetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          rst,
  input logic          imem_rsp_valid,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] fifo_count
);

  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);

  rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (outstanding != ZERO_C));

  occupancy_bounded: assert property (@(posedge clk) disable iff (!rst)
    (({1'b0, fifo_count} + {1'b0, outstanding}) <= DEPTH_W));

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: owns the fetch PC, issues in-order word requests and
// queues {pc, inst} for ID. Define FETCH_STATS_EN to add saturating event counters.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_killed,
  output logic [31:0] stat_stall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  fetch_state_t       state_r, state_n_s;
  logic [XLEN-1:0]    fetch_pc_r, fetch_pc_n_s;
  logic [XLEN-1:0]    rsp_pc_r, rsp_pc_n_s;
  logic [CW-1:0]      outstanding_r, outstanding_n_s;
  logic [CW-1:0]      kill_r, kill_n_s;
  logic [CW-1:0]      fifo_count_s;
  logic [ENTRY_W-1:0] head_s;
  logic [CW:0]        occ_s;
  logic               req_valid_s, req_fire_s;
  logic               push_s, pop_s, flush_s, drop_s;
  logic               id_valid_s;
  logic               unused_ok_s;

  assign unused_ok_s = ^redirect_pc[1:0];

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data ({rsp_pc_r, imem_rsp_data}),
    .pop       (pop_s),
    .flush     (flush_s),
    .count     (fifo_count_s),
    .head      (head_s)
  );

  assign id_valid_s = (fifo_count_s != ZERO_C);
  assign id_valid   = id_valid_s;
  assign id_pc      = head_s[ENTRY_W-1:INST_W];
  assign id_inst    = head_s[INST_W-1:0];

  // Request gating: the cap counts queued plus in-flight words so the FIFO cannot overflow.
  always_comb begin
    occ_s       = {1'b0, fifo_count_s} + {1'b0, outstanding_r};
    req_valid_s = 1'b0;
    if ((state_r != BOOT) && !redirect_valid && (occ_s < DEPTH_W)) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
  end

  assign req_fire_s     = req_valid_s && imem_req_ready;
  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;

  // In-flight count tracks handshakes and every returning response, killed or not.
  always_comb begin
    case ({req_fire_s, imem_rsp_valid})
      2'b10:   outstanding_n_s = outstanding_r + ONE_C;
      2'b01:   outstanding_n_s = outstanding_r - ONE_C;
      default: outstanding_n_s = outstanding_r;
    endcase
  end

  // PC, kill and FIFO control; a redirect overrides everything else in the cycle.
  always_comb begin
    fetch_pc_n_s = fetch_pc_r;
    rsp_pc_n_s   = rsp_pc_r;
    kill_n_s     = kill_r;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    flush_s      = 1'b0;
    drop_s       = 1'b0;
    if (redirect_valid) begin
      flush_s      = 1'b1;
      fetch_pc_n_s = {redirect_pc[XLEN-1:2], 2'b00};
      rsp_pc_n_s   = {redirect_pc[XLEN-1:2], 2'b00};
      drop_s       = imem_rsp_valid;
      // Every word still in flight is stale, including ones already marked for killing.
      kill_n_s     = imem_rsp_valid ? (outstanding_r - ONE_C) : outstanding_r;
    end else begin
      if (req_fire_s) begin
        fetch_pc_n_s = fetch_pc_r + PC_STEP;
      end else begin
        fetch_pc_n_s = fetch_pc_r;
      end
      pop_s = id_valid_s && id_ready;
      if (imem_rsp_valid && (kill_r != ZERO_C)) begin
        drop_s   = 1'b1;
        kill_n_s = kill_r - ONE_C;
      end else if (imem_rsp_valid) begin
        push_s     = 1'b1;
        rsp_pc_n_s = rsp_pc_r + PC_STEP;
      end else begin
        kill_n_s = kill_r;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      BOOT:       state_n_s = RUN;
      RUN, DRAIN: state_n_s = (kill_n_s != ZERO_C) ? DRAIN : RUN;
      default:    state_n_s = BOOT;
    endcase
  end

  // Architectural fetch state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= BOOT;
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= ZERO_C;
      kill_r        <= ZERO_C;
    end else begin
      state_r       <= state_n_s;
      fetch_pc_r    <= fetch_pc_n_s;
      rsp_pc_r      <= rsp_pc_n_s;
      outstanding_r <= outstanding_n_s;
      kill_r        <= kill_n_s;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_r, killed_r, stall_r;
  logic [31:0] kill_inc_s;

  // Killed words: dropped responses plus entries discarded by a flush.
  always_comb begin
    kill_inc_s = 32'(flush_s ? fifo_count_s : ZERO_C) + 32'(drop_s);
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_r <= 32'd0;
      killed_r  <= 32'd0;
      stall_r   <= 32'd0;
    end else begin
      fetched_r <= sat_add(fetched_r, 32'(push_s));
      killed_r  <= sat_add(killed_r, kill_inc_s);
      stall_r   <= sat_add(stall_r, 32'(id_ready && !id_valid_s));
    end
  end

  assign stat_fetched = fetched_r;
  assign stat_killed  = killed_r;
  assign stat_stall   = stall_r;
`endif

  fetch_queue_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk            (clk),
    .rst            (rst),
    .imem_rsp_valid (imem_rsp_valid),
    .outstanding    (outstanding_r),
    .fifo_count     (fifo_count_s)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order memory model with variable latency,
// scoreboard of expected ID-stage PCs, redirect table plus hand-written corner cases.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_killed, stat_stall;
`endif

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_killed    (stat_killed),
    .stat_stall     (stat_stall)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] target;
    int          lat;
    bit          rnd;
    int          pops;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  pend_t       pend_q[$];
  logic [31:0] sb_q[$];
  vec_t        vt[5];

  int          checks = 0;
  int          passed = 0;
  int          cyc, lat, pops, reqs, first_valid_cyc;
  logic [31:0] exp_req_addr, first_pop_pc, last_pop_pc;
  logic        arm_redir, redir_fired, rand_ready;
  logic [31:0] arm_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a ^ 32'h5A5A_0F0F) + 32'h0000_1111;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected ID stream and request addresses restart at every reset/redirect target.
  task automatic seed(input logic [31:0] pc);
    sb_q.delete();
    for (int i = 0; i < 64; i++) sb_q.push_back(pc + 32'(4 * i));
    exp_req_addr = pc;
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle();
    pend_t       p;
    logic [31:0] pc;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(p.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    if (arm_redir && imem_rsp_valid) begin
      redirect_valid = 1'b1;
      redirect_pc    = arm_pc;
      id_ready       = 1'b1;
      arm_redir      = 1'b0;
      redir_fired    = 1'b1;
    end
    if (rand_ready) id_ready = 1'($urandom_range(0, 1));
    if (redirect_valid) seed({redirect_pc[31:2], 2'b00});
    #1;
    if (redirect_valid) check("req_blocked_on_redirect", {31'd0, imem_req_valid}, 32'd0);
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_req_addr);
      exp_req_addr = exp_req_addr + 32'd4;
      reqs++;
      pend_q.push_back('{addr: imem_req_addr, due: cyc + lat});
    end
    if (id_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (id_valid && id_ready && !redirect_valid) begin
      check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        pc = sb_q.pop_front();
        check("id_pc", id_pc, pc);
        check("id_inst", id_inst, inst_of(pc));
      end
      if (pops == 0) first_pop_pc = id_pc;
      last_pop_pc = id_pc;
      pops++;
    end
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    cyc++;
  endtask

  // Asynchronous reset mid low-phase; the memory model is reset with it.
  task automatic apply_reset();
    #2;
    rst = 1'b0;
    #1;
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_inst", id_inst, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
`ifdef FETCH_STATS_EN
    check("rst_stat_fetched", stat_fetched, 32'd0);
    check("rst_stat_killed", stat_killed, 32'd0);
    check("rst_stat_stall", stat_stall, 32'd0);
`endif
    pend_q.delete();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    arm_redir      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    seed(32'h0000_0000);
    cyc = 0; pops = 0; reqs = 0; first_valid_cyc = -1;
  endtask

  initial begin
    vt[0] = '{32'h0000_0100, 3, 1'b0, 4, 32'h0000_0100, 32'h0000_010C};
    vt[1] = '{32'h0000_0203, 1, 1'b0, 5, 32'h0000_0200, 32'h0000_0210};
    vt[2] = '{32'hFFFF_FFFB, 2, 1'b0, 4, 32'hFFFF_FFF8, 32'h0000_0004};
    vt[3] = '{32'h0000_1000, 1, 1'b1, 8, 32'h0000_1000, 32'h0000_101C};
    vt[4] = '{32'h0000_0040, 4, 1'b0, 5, 32'h0000_0040, 32'h0000_0050};

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    id_ready = 1'b1; rand_ready = 1'b0; arm_redir = 1'b0; redir_fired = 1'b0;
    arm_pc = 32'h0; lat = 1; cyc = 0; pops = 0; reqs = 0; first_valid_cyc = -1;
    exp_req_addr = 32'h0; first_pop_pc = 32'h0; last_pop_pc = 32'h0;
    @(negedge clk);

    // Boot with 1-cycle memory and ID always ready.
    apply_reset();
    #1;
    check("boot_no_req", {31'd0, imem_req_valid}, 32'd0);
    for (int k = 0; k < 12; k++) cycle();
    check("first_valid_cycle", 32'(first_valid_cyc), 32'd3);
    check("boot_pops", 32'(pops), 32'd9);
    check("boot_first_pc", first_pop_pc, 32'h0);
    check("boot_last_pc", last_pop_pc, 32'h20);

    // ID stalled: issue stops at DEPTH, then resumes one request per pop.
    apply_reset();
    id_ready = 1'b0;
    for (int k = 0; k < 10; k++) cycle();
    #1;
    check("stall_reqs", 32'(reqs), 32'd4);
    check("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("stall_id_valid", {31'd0, id_valid}, 32'd1);
    check("stall_head_pc", id_pc, 32'h0);
    id_ready = 1'b1;
    for (int k = 0; k < 8; k++) cycle();
    check("resume_pops", 32'(pops), 32'd8);
    check("resume_reqs", 32'(reqs), 32'd11);

    // Redirect table, each applied while the previous stream is still in flight.
    lat = 3;
    for (int k = 0; k < 6; k++) cycle();
    for (int i = 0; i < 5; i++) begin
      lat = vt[i].lat;
      rand_ready = vt[i].rnd;
      id_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = vt[i].target;
      pops = 0;
      for (int k = 0; k < 200 && pops < vt[i].pops; k++) cycle();
      rand_ready = 1'b0;
      id_ready = 1'b1;
      check("vec_pops", 32'(pops), 32'(vt[i].pops));
      check("vec_first_pc", first_pop_pc, vt[i].first);
      check("vec_last_pc", last_pop_pc, vt[i].last);
    end

    // Back-to-back redirects: the second retargets while the first is draining.
    lat = 3;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0400;
    pops = 0;
    for (int k = 0; k < 60 && pops < 3; k++) cycle();
    check("double_redir_pops", 32'(pops), 32'd3);
    check("double_redir_first", first_pop_pc, 32'h0000_0400);
    check("double_redir_last", last_pop_pc, 32'h0000_0408);

    // Redirect coinciding with a response and a pop at full occupancy.
    apply_reset();
    id_ready = 1'b0;
    for (int k = 0; k < 8; k++) cycle();
    id_ready = 1'b1;
    cycle();
    id_ready = 1'b0;
    arm_pc = 32'h0000_0080;
    arm_redir = 1'b1;
    redir_fired = 1'b0;
    pops = 0;
    for (int k = 0; k < 10 && !redir_fired; k++) cycle();
    check("full_redir_fired", {31'd0, redir_fired}, 32'd1);
    #1;
    check("full_redir_flushed", {31'd0, id_valid}, 32'd0);
    arm_redir = 1'b0;
    id_ready = 1'b1;
    for (int k = 0; k < 30 && pops < 3; k++) cycle();
    check("full_redir_pops", 32'(pops), 32'd3);
    check("full_redir_first", first_pop_pc, 32'h0000_0080);

    // Reset with requests in flight and the FIFO half full.
    apply_reset();
    lat = 3;
    id_ready = 1'b0;
    for (int k = 0; k < 6; k++) cycle();
    check("pre_reset_reqs", 32'(reqs), 32'd4);
    apply_reset();
    lat = 1;
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    check("post_reset_reqs", 32'(reqs), 32'd3);
    check("post_reset_first_pc", first_pop_pc, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
